// File: rtl/mms_stream.sv
// Streaming frame extremum: accepts N operands over valid/ready and returns the
// frame max (select=0) or min (select=1) plus the winner's position in the frame.
module mms_stream #(
  parameter int DATA_W = 8,
  parameter int N      = 4,
  parameter int IDX_W  = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              select,
  input  logic [DATA_W-1:0] number,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [IDX_W-1:0]  result_idx
);

  // cnt has to represent N itself, so it is one bit wider than IDX_W for powers of two
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_best;
  logic [IDX_W-1:0]    r_best_idx;
  logic                r_sel;

  logic                w_xfer;
  logic                w_better;
  logic                w_last;

  assign w_xfer   = in_valid && in_ready;
  // strict compare: ties keep the earlier operand
  assign w_better = r_sel ? (number < r_best) : (number > r_best);
  assign w_last   = (r_cnt == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // handshake outputs depend on state alone; no combinational path from out_ready
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_sel      <= 1'b0;
    end else if (w_xfer) begin
      if (r_state == IDLE) begin
        r_sel      <= select;
        r_best     <= number;
        r_best_idx <= '0;
        r_cnt      <= CNT_W'(1);
      end else begin
        r_cnt <= r_cnt + 1'b1;
        if (w_better) begin
          r_best     <= number;
          r_best_idx <= r_cnt[IDX_W-1:0];
        end
      end
    end
  end

  assign result     = r_best;
  assign result_idx = r_best_idx;

endmodule

// File: tb/tb_mms_stream.sv
// Scoreboard bench for mms_stream: directed frames plus random sweeps on N=4 and
// N=8 instances, checked against a queue-based frame extremum model.
module tb_mms_stream;

  typedef struct {
    logic [7:0] v;
    logic [7:0] ix;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=4 instance
  logic       reset, in_valid, in_ready, select, out_valid, out_ready;
  logic [7:0] number, result;
  logic [1:0] result_idx;
  // N=8 instance
  logic       b_reset, b_in_valid, b_in_ready, b_select, b_out_valid, b_out_ready;
  logic [7:0] b_number, b_result;
  logic [2:0] b_result_idx;

  mms_stream #(.DATA_W(8), .N(4)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .number(number), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .result_idx(result_idx));

  mms_stream #(.DATA_W(8), .N(8)) dut_b (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .select(b_select), .number(b_number), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .result(b_result), .result_idx(b_result_idx));

  exp_t       a_exp[$], b_exp[$];
  logic [7:0] a_ops[$], b_ops[$];
  logic       a_fsel, b_fsel;
  bit         a_rand = 0, b_rand = 0, b_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Reference: the extremal value of the frame, and the first position holding it.
  function automatic void ref_ext(input logic [7:0] ops[$], input logic sel,
                                  output logic [7:0] v, output logic [7:0] ix);
    logic [7:0] m[$];
    int         q[$];
    if (sel) m = ops.min();
    else     m = ops.max();
    v  = m[0];
    q  = ops.find_first_index(x) with (x == v);
    ix = 8'(q[0]);
  endfunction

  function automatic logic [7:0] rnd();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 3));
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic a_accept(input logic [7:0] v, input logic s);
    exp_t e;
    if (a_ops.size() == 0) a_fsel = s;
    a_ops.push_back(v);
    if (a_ops.size() == 4) begin
      ref_ext(a_ops, a_fsel, e.v, e.ix);
      a_exp.push_back(e);
      a_ops.delete();
    end
  endtask

  task automatic b_accept(input logic [7:0] v, input logic s);
    exp_t e;
    if (b_ops.size() == 0) b_fsel = s;
    b_ops.push_back(v);
    if (b_ops.size() == 8) begin
      ref_ext(b_ops, b_fsel, e.v, e.ix);
      b_exp.push_back(e);
      b_ops.delete();
    end
  endtask

  // Must be entered just after a rising edge; returns just after the transfer edge.
  task automatic send_a(input logic [7:0] v, input logic s);
    int t = 0;
    number = v; select = s; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++t > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL a_send_timeout: got in_ready 0 expected 1");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_accept(v, s);
  endtask

  task automatic send_b(input logic [7:0] v, input logic s);
    int t = 0;
    b_number = v; b_select = s; b_in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (b_in_ready) break;
      if (++t > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL b_send_timeout: got in_ready 0 expected 1");
        b_in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_accept(v, s);
  endtask

  task automatic reset_a();
    reset = 1'b1;
    sync();
    reset = 1'b0;
    a_ops.delete();
    a_exp.delete();
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"},   in_ready,   1);
    chk({nm, "_out_valid"},  out_valid,  0);
    chk({nm, "_result"},     result,     0);
    chk({nm, "_result_idx"}, result_idx, 0);
  endtask

  // Monitor A: handoff scoreboard, state-only in_ready, and hold stability under backpressure
  initial begin : mon_a
    exp_t       e;
    bit         hold = 0;
    logic [7:0] hv;
    logic [1:0] hi;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        hold = 0;
      end else begin
        chk("a_in_ready_vs_valid", in_ready, !out_valid);
        if (hold) begin
          chk("a_hold_valid", out_valid, 1);
          chk("a_hold_result", result, hv);
          chk("a_hold_idx", result_idx, hi);
        end
        if (out_valid && out_ready) begin
          if (a_exp.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL a_extra_result: got result %0d expected no result", result);
          end else begin
            e = a_exp.pop_front();
            chk("a_result", result, e.v);
            chk("a_result_idx", result_idx, e.ix);
          end
        end
        hold = out_valid && !out_ready;
        hv = result; hi = result_idx;
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (b_reset === 1'b0) begin
        chk("b_in_ready_vs_valid", b_in_ready, !b_out_valid);
        if (b_out_valid && b_out_ready) begin
          if (b_exp.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL b_extra_result: got result %0d expected no result", b_result);
          end else begin
            e = b_exp.pop_front();
            chk("b_result", b_result, e.v);
            chk("b_result_idx", b_result_idx, e.ix);
          end
        end
      end
    end
  end

  initial begin : ready_rand
    forever begin
      @(posedge clk); #1;
      if (a_rand) out_ready   = ($urandom_range(0, 2) != 0);
      if (b_rand) b_out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin : drv_b
    b_reset = 1'b1; b_in_valid = 1'b0; b_select = 1'b0; b_number = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 b_reset = 1'b0;
    b_rand = 1;
    for (int f = 0; f < 30; f++)
      for (int k = 0; k < 8; k++) begin
        repeat ($urandom_range(0, 2)) sync();
        send_b(rnd(), 1'($urandom_range(0, 1)));
      end
    b_rand = 0;
    sync();
    b_out_ready = 1'b1;
    for (int t = 0; t < 50 && b_exp.size() != 0; t++) sync();
    chk("b_drain_pending", b_exp.size(), 0);
    b_done = 1;
  end

  initial begin : drv_a
    reset = 1'b1; in_valid = 1'b0; select = 1'b0; number = '0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    sync();
    reset = 1'b0;

    // max frame with a tie: earliest 200 wins, out_valid is a single-cycle pulse
    send_a(12, 0); send_a(200, 0); send_a(7, 0); send_a(200, 0);
    @(negedge clk); chk("t1_valid_pulse", out_valid, 1);
    @(negedge clk); chk("t1_valid_drop", out_valid, 0);
    sync();

    // min frame; select toggles after the first operand are ignored
    send_a(50, 1); send_a(3, 0); send_a(3, 1); send_a(90, 0);
    sync();

    // backpressure: result held, 77 waits on number until the handoff
    out_ready = 1'b0;
    send_a(9, 0); send_a(8, 0); send_a(7, 0); send_a(6, 0);
    number = 77; select = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", result, 9);
      chk("bp_result_idx", result_idx, 0);
      sync();
    end
    out_ready = 1'b1;
    send_a(77, 0); send_a(1, 0); send_a(2, 0); send_a(3, 0);
    sync();

    // gaps between operands
    send_a(0, 0);   repeat (3) sync();
    send_a(255, 0); repeat (3) sync();
    send_a(1, 0);   repeat (3) sync();
    send_a(0, 0);   repeat (3) sync();

    // reset mid-frame, then reset while a result is pending
    send_a(1, 0); send_a(2, 0);
    reset_a();
    @(negedge clk); chk_reset_vals("rst_mid");
    sync();
    out_ready = 1'b0;
    send_a(5, 0); send_a(6, 0); send_a(7, 0); send_a(8, 0);
    @(negedge clk); chk("rst_done_pre_valid", out_valid, 1);
    sync();
    reset_a();
    @(negedge clk); chk("rst_done_valid", out_valid, 0);
    chk("rst_done_result", result, 0);
    sync();
    out_ready = 1'b1;
    send_a(4, 1); send_a(4, 1); send_a(4, 1); send_a(4, 1);
    sync();

    // random sweep with input gaps and random out_ready stalls
    a_rand = 1;
    for (int f = 0; f < 50; f++)
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 2)) sync();
        send_a(rnd(), 1'($urandom_range(0, 1)));
      end
    a_rand = 0;
    sync();
    out_ready = 1'b1;
    for (int t = 0; t < 50 && a_exp.size() != 0; t++) sync();
    chk("a_drain_pending", a_exp.size(), 0);

    for (int t = 0; t < 20000 && !b_done; t++) sync();
    chk("b_finished", b_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
